// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared types for the LC-3b memory hierarchy: the cache-line
//                type, the cache arbiter FSM states, the requester identity
//                used for round-robin history, and the tie-break helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3b_types;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    // Picks the requester to serve next. With both caches asking, the one
    // that was not served last wins, so neither side can be starved.
    // Only meaningful when at least one request is present.
    function automatic arb_req_t rr_pick(input logic     icache_req,
                                         input logic     dcache_req,
                                         input arb_req_t last);
        if (icache_req && dcache_req) begin
            return (last == REQ_I) ? REQ_D : REQ_I;
        end else if (dcache_req) begin
            return REQ_D;
        end else begin
            return REQ_I;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Shares the single physical-memory port between ICache and
//                DCache line-miss traffic. One requester is granted at a time;
//                its address, writeback line and operation are latched at
//                grant and drive pmem until pmem_resp. The response is routed
//                back to the granted requester only. Ties are broken
//                round-robin, D first after reset.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst        clock; asynchronous active-high reset
//    i_pmem_read     ICache line read request (level, held until i_pmem_resp)
//    i_pmem_addr     ICache line address
//    i_pmem_rdata    line returned to ICache (holds last returned line)
//    i_pmem_resp     one-cycle completion pulse to ICache
//    d_pmem_read     DCache line read request (level)
//    d_pmem_write    DCache writeback request (level)
//    d_pmem_addr     DCache line address
//    d_pmem_wdata    DCache writeback line
//    d_pmem_rdata    line returned to DCache (holds last returned line)
//    d_pmem_resp     one-cycle completion pulse to DCache
//    pmem_read       read strobe to memory
//    pmem_write      write strobe to memory
//    pmem_addr       latched address of the granted requester
//    pmem_wdata      latched writeback line
//    pmem_rdata      memory read data
//    pmem_resp       memory completion, valid one cycle
// ============================================================================
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state;
    arb_state_t            state_next;
    arb_req_t              last_grant;
    arb_req_t              winner;

    logic                  icache_req;
    logic                  dcache_req;
    logic                  grant_now;

    logic [ADDR_WIDTH-1:0] addr_latch;
    logic [LINE_WIDTH-1:0] wdata_latch;
    logic                  op_write;
    logic [LINE_WIDTH-1:0] i_rdata_hold;
    logic [LINE_WIDTH-1:0] d_rdata_hold;

    assign icache_req = i_pmem_read;
    assign dcache_req = d_pmem_read | d_pmem_write;
    assign winner     = rr_pick(icache_req, dcache_req, last_grant);
    assign grant_now  = (state == IDLE) && (icache_req || dcache_req);

    // ------------------------------------------------------------------
    // Next-state logic. Arbitration only happens in IDLE; RELEASE is a
    // dead cycle so the served cache can drop its request first.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (icache_req || dcache_req) begin
                    state_next = (winner == REQ_D) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Grant-time latches and returned-line holding registers. Once
    // granted, requester inputs are ignored until the next grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= REQ_I;
            addr_latch   <= '0;
            wdata_latch  <= '0;
            op_write     <= 1'b0;
            i_rdata_hold <= '0;
            d_rdata_hold <= '0;
        end else begin
            if (grant_now) begin
                last_grant <= winner;
                if (winner == REQ_D) begin
                    addr_latch  <= d_pmem_addr;
                    wdata_latch <= d_pmem_wdata;
                    // Read and write together is illegal; write takes priority.
                    op_write    <= d_pmem_write;
                end else begin
                    addr_latch  <= i_pmem_addr;
                    op_write    <= 1'b0;
                end
            end
            if (pmem_resp && (state == GRANT_I)) begin
                i_rdata_hold <= pmem_rdata;
            end
            if (pmem_resp && (state == GRANT_D)) begin
                d_rdata_hold <= pmem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Strobes come from the state register, so the async
    // reset drops them without waiting for a clock edge. Resp and rdata
    // follow pmem_resp in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = i_rdata_hold;
        d_pmem_rdata = d_rdata_hold;
        case (state)
            GRANT_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    i_pmem_rdata = pmem_rdata;
                end
            end
            GRANT_D: begin
                pmem_read  = ~op_write;
                pmem_write = op_write;
                if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    d_pmem_rdata = pmem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign pmem_addr  = addr_latch;
    assign pmem_wdata = wdata_latch;

    a_no_dual_dcache_op: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

    a_single_resp: assert property (@(posedge clk) disable iff (rst)
        !(i_pmem_resp && d_pmem_resp));

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter. Directed scenarios
//                plus a randomized run checked against a transaction-level
//                model (pending requests, round-robin history, returned lines).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_addr;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_addr;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pmem_read  (i_pmem_read),
        .i_pmem_addr  (i_pmem_addr),
        .i_pmem_rdata (i_pmem_rdata),
        .i_pmem_resp  (i_pmem_resp),
        .d_pmem_read  (d_pmem_read),
        .d_pmem_write (d_pmem_write),
        .d_pmem_addr  (d_pmem_addr),
        .d_pmem_wdata (d_pmem_wdata),
        .d_pmem_rdata (d_pmem_rdata),
        .d_pmem_resp  (d_pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr    (pmem_addr),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_addr = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_strobe(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!(pmem_read || pmem_write) && waited < limit);
    endtask

    // Holds the grant for lat cycles, returns the line, then steps into the
    // following dead cycle. Reports what the requesters saw.
    task automatic serve(input int lat, input logic [127:0] line,
                         output logic got_i, output logic got_d,
                         output logic [127:0] ird, output logic [127:0] drd,
                         output int spur, output logic strobe_ok);
        spur = 0; strobe_ok = 1'b1;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk); pmem_resp = 1'b0; pmem_rdata = rand_line(); #1;
            if (i_pmem_resp || d_pmem_resp) spur++;
            if (!(pmem_read || pmem_write)) strobe_ok = 1'b0;
        end
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = line; #1;
        got_i = i_pmem_resp; got_d = d_pmem_resp; ird = i_pmem_rdata; drd = d_pmem_rdata;
        if (!(pmem_read || pmem_write)) strobe_ok = 1'b0;
        @(negedge clk); pmem_resp = 1'b0; pmem_rdata = rand_line(); #1;
        if (i_pmem_resp || d_pmem_resp) spur++;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {pmem_read, pmem_write}); else n_pass++;
        n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) $display("FAIL reset_resp got %b want 00", {i_pmem_resp, d_pmem_resp}); else n_pass++;
        n_checks++; if (pmem_addr !== 16'h0) $display("FAIL reset_addr got %h want 0", pmem_addr); else n_pass++;
        n_checks++; if (pmem_wdata !== 128'h0) $display("FAIL reset_wdata got %h want 0", pmem_wdata); else n_pass++;
        n_checks++; if ({i_pmem_rdata, d_pmem_rdata} !== 256'h0) $display("FAIL reset_rdata got %h/%h want 0", i_pmem_rdata, d_pmem_rdata); else n_pass++;
        // A stray completion with nobody granted must not reach either cache.
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = rand_line(); #1;
        n_checks++; if ({i_pmem_resp, d_pmem_resp, pmem_read, pmem_write} !== 4'b0) $display("FAIL reset_stray got %b want 0000", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write}); else n_pass++;
        @(negedge clk); pmem_resp = 1'b0; #1;
    endtask

    task automatic test_i_read();
        logic [127:0] line;
        int rd_cycles, iresp_n, dresp_n, addr_bad;
        reset_dut();
        line = rand_line();
        i_pmem_addr = 16'h0040; i_pmem_read = 1'b1;
        rd_cycles = 0; iresp_n = 0; dresp_n = 0; addr_bad = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            pmem_resp  = (c == 6);
            pmem_rdata = (c == 6) ? line : rand_line();
            if (c == 7) i_pmem_read = 1'b0;
            #1;
            if (pmem_read) rd_cycles++;
            if (i_pmem_resp) iresp_n++;
            if (d_pmem_resp) dresp_n++;
            if (pmem_read && pmem_addr !== 16'h0040) addr_bad++;
            if (c == 1) begin
                n_checks++; if (pmem_read !== 1'b1) $display("FAIL iread_first got %b want 1", pmem_read); else n_pass++;
            end
            if (c == 6) begin
                n_checks++; if (i_pmem_rdata !== line) $display("FAIL iread_rdata got %h want %h", i_pmem_rdata, line); else n_pass++;
            end
            if (c == 7) begin
                n_checks++; if (pmem_read !== 1'b0) $display("FAIL iread_release got %b want 0", pmem_read); else n_pass++;
            end
            if (c == 8) begin
                n_checks++; if (i_pmem_rdata !== line) $display("FAIL iread_hold got %h want %h", i_pmem_rdata, line); else n_pass++;
            end
        end
        n_checks++; if (rd_cycles != 6) $display("FAIL iread_len got %0d want 6", rd_cycles); else n_pass++;
        n_checks++; if (iresp_n != 1) $display("FAIL iread_resp got %0d want 1", iresp_n); else n_pass++;
        n_checks++; if (dresp_n != 0) $display("FAIL iread_dresp got %0d want 0", dresp_n); else n_pass++;
        n_checks++; if (addr_bad != 0) $display("FAIL iread_addr got %0d bad cycles want 0", addr_bad); else n_pass++;
    endtask

    task automatic test_tie();
        int w, spur; logic gi, gd, ok; logic [127:0] ird, drd, l1, l2;
        reset_dut();
        l1 = rand_line(); l2 = rand_line();
        i_pmem_addr = 16'h0040; i_pmem_read = 1'b1;
        d_pmem_addr = 16'h1000; d_pmem_read = 1'b1;
        wait_strobe(4, w);
        n_checks++; if (w != 1 || pmem_addr !== 16'h1000) $display("FAIL tie_first got wait %0d addr %h want 1/1000", w, pmem_addr); else n_pass++;
        serve(2, l1, gi, gd, ird, drd, spur, ok);
        n_checks++; if ({gi, gd} !== 2'b01 || drd !== l1) $display("FAIL tie_dresp got %b/%h want 01/%h", {gi, gd}, drd, l1); else n_pass++;
        n_checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL tie_release got %b want 00", {pmem_read, pmem_write}); else n_pass++;
        d_pmem_read = 1'b0;
        wait_strobe(4, w);
        n_checks++; if (w != 2 || pmem_addr !== 16'h0040) $display("FAIL tie_second got wait %0d addr %h want 2/0040", w, pmem_addr); else n_pass++;
        serve(1, l2, gi, gd, ird, drd, spur, ok);
        n_checks++; if ({gi, gd} !== 2'b10 || ird !== l2 || spur != 0) $display("FAIL tie_iresp got %b/%h spur %0d want 10/%h", {gi, gd}, ird, spur, l2); else n_pass++;
        i_pmem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w, spur; logic gi, gd, ok, exp_d; logic [127:0] ird, drd, line;
        reset_dut();
        i_pmem_addr = 16'h0100; i_pmem_read = 1'b1;
        d_pmem_addr = 16'h0200; d_pmem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            wait_strobe(6, w);
            n_checks++; if (w != ((k == 0) ? 1 : 2) || pmem_addr !== (exp_d ? 16'h0200 : 16'h0100))
                $display("FAIL b2b_grant%0d got wait %0d addr %h want %0d/%h", k, w, pmem_addr, (k == 0) ? 1 : 2, exp_d ? 16'h0200 : 16'h0100); else n_pass++;
            line = rand_line();
            serve($urandom_range(0, 3), line, gi, gd, ird, drd, spur, ok);
            n_checks++; if ({gi, gd} !== {~exp_d, exp_d} || spur != 0 || !ok) $display("FAIL b2b_resp%0d got %b spur %0d ok %b want %b", k, {gi, gd}, spur, ok, {~exp_d, exp_d}); else n_pass++;
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    endtask

    task automatic test_write_hold();
        int w, dresp_n, bad; logic [127:0] a5;
        reset_dut();
        a5 = {16{8'hA5}};
        d_pmem_addr = 16'h2000; d_pmem_wdata = a5; d_pmem_write = 1'b1;
        wait_strobe(4, w);
        n_checks++; if ({pmem_write, pmem_read} !== 2'b10 || w != 1) $display("FAIL wr_strobe got %b wait %0d want 10/1", {pmem_write, pmem_read}, w); else n_pass++;
        dresp_n = 0; bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            d_pmem_addr = 16'($urandom()); d_pmem_wdata = rand_line();
            pmem_resp = (c == 3);
            if (c == 4) d_pmem_write = 1'b0;
            #1;
            if (d_pmem_resp) dresp_n++;
            if (c <= 3 && (pmem_addr !== 16'h2000 || pmem_wdata !== a5 || pmem_write !== 1'b1)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL wr_latched got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (dresp_n != 1) $display("FAIL wr_resp got %0d want 1", dresp_n); else n_pass++;
        n_checks++; if (pmem_write !== 1'b0) $display("FAIL wr_release got %b want 0", pmem_write); else n_pass++;
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w, spur; logic gi, gd, ok; logic [127:0] ird, drd, line;
        reset_dut();
        d_pmem_addr = 16'h3000; d_pmem_read = 1'b1;
        wait_strobe(4, w);
        @(negedge clk); #1;
        n_checks++; if (pmem_read !== 1'b1) $display("FAIL rstmid_pre got %b want 1", pmem_read); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (pmem_read !== 1'b0 || pmem_addr !== 16'h0) $display("FAIL rstmid_drop got %b addr %h want 0/0000", pmem_read, pmem_addr); else n_pass++;
        d_pmem_read = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = rand_line(); #1;
        n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00 || d_pmem_rdata !== 128'h0) $display("FAIL rstmid_stray got %b rdata %h want 00/0", {i_pmem_resp, d_pmem_resp}, d_pmem_rdata); else n_pass++;
        @(negedge clk); pmem_resp = 1'b0; #1;
        i_pmem_addr = 16'h0440; i_pmem_read = 1'b1;
        wait_strobe(4, w);
        n_checks++; if (w != 1 || pmem_read !== 1'b1 || pmem_addr !== 16'h0440) $display("FAIL rstmid_next got wait %0d addr %h want 1/0440", w, pmem_addr); else n_pass++;
        line = rand_line();
        serve(2, line, gi, gd, ird, drd, spur, ok);
        n_checks++; if ({gi, gd} !== 2'b10 || ird !== line) $display("FAIL rstmid_resp got %b/%h want 10/%h", {gi, gd}, ird, line); else n_pass++;
        i_pmem_read = 1'b0;
    endtask

    task automatic test_drop();
        int w, spur; logic gi, gd, ok; logic [127:0] ird, drd, line;
        reset_dut();
        i_pmem_addr = 16'h0500; i_pmem_read = 1'b1;
        wait_strobe(4, w);
        @(negedge clk); i_pmem_read = 1'b0; #1;
        n_checks++; if (pmem_read !== 1'b1) $display("FAIL drop_hold got %b want 1", pmem_read); else n_pass++;
        line = rand_line();
        serve(3, line, gi, gd, ird, drd, spur, ok);
        n_checks++; if ({gi, gd} !== 2'b10 || !ok || spur != 0 || ird !== line) $display("FAIL drop_resp got %b ok %b spur %0d want 10/1/0", {gi, gd}, ok, spur); else n_pass++;
    endtask

    // Transaction-level model: which caches are waiting, who was served
    // last, and what line each cache was last given.
    task automatic test_random();
        logic pend_i, pend_d, wr_d, last_was_d, win_d, in_release;
        logic [15:0] addr_i, addr_d, exp_addr;
        logic [127:0] wdata_d, last_i, last_d, line, ird, drd;
        logic gi, gd, ok;
        int w, spur, exp_wait;
        reset_dut();
        pend_i = 0; pend_d = 0; last_was_d = 0; in_release = 0;
        last_i = '0; last_d = '0; wr_d = 0; addr_i = '0; addr_d = '0; wdata_d = '0;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) @(negedge clk);
                #1;
                in_release = 0;
            end
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; addr_i = 16'($urandom());
            end
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1; addr_d = 16'($urandom()); wr_d = $urandom_range(0, 1) == 1; wdata_d = rand_line();
            end
            if (!pend_i && !pend_d) begin
                pend_i = 1; addr_i = 16'($urandom());
            end
            i_pmem_read = pend_i; i_pmem_addr = addr_i;
            d_pmem_read = pend_d && !wr_d; d_pmem_write = pend_d && wr_d;
            d_pmem_addr = addr_d; d_pmem_wdata = wdata_d;

            win_d     = (pend_i && pend_d) ? !last_was_d : pend_d;
            exp_addr  = win_d ? addr_d : addr_i;
            exp_wait  = in_release ? 2 : 1;
            wait_strobe(6, w);
            n_checks++; if (w != exp_wait || pmem_addr !== exp_addr) $display("FAIL rnd_grant%0d got wait %0d addr %h want %0d/%h", t, w, pmem_addr, exp_wait, exp_addr); else n_pass++;
            n_checks++; if ({pmem_read, pmem_write} !== ((win_d && wr_d) ? 2'b01 : 2'b10) || (win_d && wr_d && pmem_wdata !== wdata_d))
                $display("FAIL rnd_op%0d got %b wdata %h want wr=%b", t, {pmem_read, pmem_write}, pmem_wdata, win_d && wr_d); else n_pass++;

            // The granted cache scribbles on its inputs; the latched copy must win.
            if (win_d) begin d_pmem_addr = 16'($urandom()); d_pmem_wdata = rand_line(); end
            else       begin i_pmem_addr = 16'($urandom()); end

            line = rand_line();
            serve($urandom_range(0, 3), line, gi, gd, ird, drd, spur, ok);
            if (win_d) last_d = line; else last_i = line;
            n_checks++; if ({gi, gd} !== {~win_d, win_d} || spur != 0 || !ok) $display("FAIL rnd_resp%0d got %b spur %0d ok %b want %b", t, {gi, gd}, spur, ok, {~win_d, win_d}); else n_pass++;
            n_checks++; if ((win_d ? drd : ird) !== line) $display("FAIL rnd_rdata%0d got %h want %h", t, win_d ? drd : ird, line); else n_pass++;
            n_checks++; if (i_pmem_rdata !== last_i || d_pmem_rdata !== last_d || pmem_addr !== exp_addr || {pmem_read, pmem_write} !== 2'b00)
                $display("FAIL rnd_release%0d got %h/%h addr %h strobes %b", t, i_pmem_rdata, d_pmem_rdata, pmem_addr, {pmem_read, pmem_write}); else n_pass++;

            last_was_d = win_d;
            if (win_d) begin pend_d = 0; d_pmem_read = 0; d_pmem_write = 0; end
            else       begin pend_i = 0; i_pmem_read = 0; end
            in_release = 1;
        end
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_i_read();
        test_tie();
        test_back_to_back();
        test_write_hold();
        test_reset_mid();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got no completion want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
